muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. It accepts one M-extension operation at a time and computes it over a fixed number of cycles with a start/busy/done handshake. It then holds a 64-bit result for the pipeline to carry to writeback. Writeback selects the result halves:
- Multiply ops: bits [31:0] are the low product and bits [63:32] the high product.
- Divide ops: bits [31:0] are the quotient and bits [63:32] the remainder.

---
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per CALC cycle,
// followed by a FIXUP cycle that applies signs and special-case results.
// Optional build macro MULDIV_FASTPATH_EN: divide-by-zero, signed overflow
// and multiply-by-zero skip CALC and finish two cycles after acceptance.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic              kill,
  input  logic [XLEN-1:0]   SrcA,
  input  logic [XLEN-1:0]   SrcB,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] MulResult
);

  localparam int unsigned   CW      = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic                is_div_q, is_div_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic                divz_q, divz_d;
  logic                ovf_q, ovf_d;
  logic [XLEN-1:0]     a_q, a_d;        // multiplier (shifts right) / dividend->quotient (shifts left)
  logic [2*XLEN-1:0]   mcand_q, mcand_d; // multiplicand (shifts left); low half is the divisor
  logic [2*XLEN-1:0]   acc_q, acc_d;    // product accumulator
  logic [XLEN-1:0]     rem_q, rem_d;    // partial remainder
  logic [XLEN-1:0]     srca_q, srca_d;  // raw rs1, needed for the divide-by-zero remainder
  logic [2*XLEN-1:0]   result_q, result_d;

  logic                accept;
  logic                signed_a, signed_b;
  logic                neg_a, neg_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                cap_divz, cap_ovf, fast;
  logic [XLEN:0]       div_shift, div_diff;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix;
  logic [2*XLEN-1:0]   fix_result;

  assign busy      = (state_q == S_CALC) || (state_q == S_FIXUP);
  assign done      = (state_q == S_DONE);
  assign MulResult = result_q;

  // Operand decode: sign handling, magnitudes and special-case detection.
  always_comb begin
    accept   = start && !kill && ((state_q == S_IDLE) || (state_q == S_DONE));
    signed_a = op inside {3'b001, 3'b010, 3'b100, 3'b110};
    signed_b = op inside {3'b001, 3'b100, 3'b110};
    neg_a    = signed_a && SrcA[XLEN-1];
    neg_b    = signed_b && SrcB[XLEN-1];
    mag_a    = neg_a ? -SrcA : SrcA;
    mag_b    = neg_b ? -SrcB : SrcB;
    cap_divz = op[2] && (SrcB == '0);
    cap_ovf  = op[2] && !op[0] && (SrcA == MIN_NEG) && (SrcB == '1);
`ifdef MULDIV_FASTPATH_EN
    fast     = cap_divz || cap_ovf || (!op[2] && ((SrcA == '0) || (SrcB == '0)));
`else
    fast     = 1'b0;
`endif
  end

  // Final sign application and special-case overrides used in FIXUP.
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -a_q : a_q;
    rem_fix  = sign_a_q ? -rem_q : rem_q;
    if (divz_q) begin
      quo_fix = '1;
      rem_fix = srca_q;
    end else if (ovf_q) begin
      quo_fix = MIN_NEG;
      rem_fix = '0;
    end
    fix_result = is_div_q ? {rem_fix, quo_fix} : prod_fix;
  end

  // Next-state logic; kill overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = fast ? S_FIXUP : S_CALC;
      S_CALC: begin
        if (kill)                         state_d = S_IDLE;
        else if (count_q == CW'(XLEN-1))  state_d = S_FIXUP;
      end
      S_FIXUP: state_d = kill ? S_IDLE : S_DONE;
      S_DONE:  state_d = accept ? (fast ? S_FIXUP : S_CALC) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: capture on accept, iterate in CALC, publish in FIXUP.
  always_comb begin
    count_d   = count_q;
    is_div_d  = is_div_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    divz_d    = divz_q;
    ovf_d     = ovf_q;
    a_d       = a_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    srca_d    = srca_q;
    result_d  = result_q;
    div_shift = {rem_q, a_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand_q[XLEN-1:0]};
    if (accept) begin
      count_d  = '0;
      is_div_d = op[2];
      sign_a_d = neg_a;
      sign_b_d = neg_b;
      divz_d   = cap_divz;
      ovf_d    = cap_ovf;
      a_d      = mag_a;
      mcand_d  = {{XLEN{1'b0}}, mag_b};
      acc_d    = '0;
      rem_d    = '0;
      srca_d   = SrcA;
    end else if (state_q == S_CALC) begin
      count_d = count_q + CW'(1);
      if (is_div_q) begin
        // Restoring step: remainder stays below the divisor, so the
        // restored or subtracted value always fits back in XLEN bits.
        if (!div_diff[XLEN]) begin
          rem_d = div_diff[XLEN-1:0];
          a_d   = {a_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = div_shift[XLEN-1:0];
          a_d   = {a_q[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_d   = acc_q + (a_q[0] ? mcand_q : '0);
        mcand_d = mcand_q << 1;
        a_d     = a_q >> 1;
      end
    end else if ((state_q == S_FIXUP) && !kill) begin
      result_d = fix_result;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      divz_q   <= 1'b0;
      ovf_q    <= 1'b0;
      a_q      <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      srca_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      divz_q   <= divz_d;
      ovf_q    <= ovf_d;
      a_q      <= a_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      srca_q   <= srca_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model plus a
// per-cycle compare of busy/done/MulResult, and directed literal checks.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, kill;
  logic [2:0]  op;
  logic [31:0] SrcA, SrcB;
  logic        busy, done;
  logic [63:0] MulResult;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

`ifdef MULDIV_FASTPATH_EN
  localparam int FAST = 2;
`else
  localparam int FAST = 34;
`endif

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .kill      (kill),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .busy      (busy),
    .done      (done),
    .MulResult (MulResult)
  );

  always #5 clk = ~clk;

  // Reference arithmetic from the RV32M definitions.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    int signed   sa, sb;
    logic [31:0] q, r;
    case (o)
      3'b000, 3'b011: begin ea = {32'h0, a};        eb = {32'h0, b};        return ea * eb; end
      3'b001:         begin ea = {{32{a[31]}}, a};  eb = {{32{b[31]}}, b};  return ea * eb; end
      3'b010:         begin ea = {{32{a[31]}}, a};  eb = {32'h0, b};        return ea * eb; end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (!o[0]) begin
          if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
          sa = $signed(a);
          sb = $signed(b);
          q  = $unsigned(sa / sb);
          r  = $unsigned(sa % sb);
        end else begin
          q = a / b;
          r = a % b;
        end
        return {r, q};
      end
    endcase
  endfunction

  function automatic bit ref_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FASTPATH_EN
    if (o[2]) return (b == 32'h0) || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
    return (a == 32'h0) || (b == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  // Observable-behaviour model: cycles remaining, pending result, done pulse.
  int          m_rem  = 0;
  bit          m_done = 1'b0;
  logic [63:0] m_res  = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (!rst_n) begin
      m_rem = 0;
      m_res = '0;
    end else if (m_rem != 0) begin
      if (kill) m_rem = 0;
      else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_res  = m_pend;
          m_done = 1'b1;
        end
      end
    end else if (start && !kill) begin
      m_pend = ref_result(op, SrcA, SrcB);
      m_rem  = ref_fast(op, SrcA, SrcB) ? 1 : 33;
    end
  end

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check64("busy", {63'h0, busy}, {63'h0, m_rem != 0});
      check64("done", {63'h0, done}, {63'h0, m_done});
      check64("MulResult", MulResult, m_res);
    end
  end

  // Counts edges from acceptance (inclusive) until done is seen; bounded.
  task automatic wait_done(output int lat);
    bit got;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done) got = 1'b1;
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res, input int exp_lat, input string nm);
    int lat;
    @(negedge clk);
    op = o; SrcA = a; SrcB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check_int({nm, "_lat"}, lat, exp_lat);
    check64({nm, "_res"}, MulResult, exp_res);
  endtask

  task automatic watch_no_done(input int n, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check64(nm, {63'h0, seen}, 64'h0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 3'b000; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check64("rst_busy", {63'h0, busy}, 64'h0);
    check64("rst_done", {63'h0, done}, 64'h0);
    check64("rst_res", MulResult, 64'h0);
    @(negedge clk); rst_n = 1'b1;

    run_op(3'b001, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE, 34, "mulh");
    run_op(3'b011, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE, 34, "mulhu");
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_80000000, 34, "mulhsu");
    run_op(3'b000, 32'h00000003, 32'hFFFFFFFF, 64'h00000002_FFFFFFFD, 34, "mul");
    run_op(3'b000, 32'h00000000, 32'h00000005, 64'h00000000_00000000, FAST, "mul_zero");
    run_op(3'b100, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 34, "div_neg");
    run_op(3'b110, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 34, "rem_neg");
    run_op(3'b111, 32'd100,      32'd7,        64'h00000002_0000000E, 34, "remu");
    run_op(3'b101, 32'h00000007, 32'h00000000, 64'h00000007_FFFFFFFF, FAST, "divu_by0");
    run_op(3'b100, 32'h80000000, 32'h00000000, 64'h80000000_FFFFFFFF, FAST, "div_by0");
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, FAST, "div_ovf");

    // kill together with start in IDLE starts nothing
    repeat (2) @(negedge clk);
    op = 3'b011; SrcA = 32'd5; SrcB = 32'd7; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check64("kill_start_idle", {63'h0, busy}, 64'h0);

    // kill at CALC cycle 10
    @(negedge clk);
    op = 3'b011; SrcA = 32'd5; SrcB = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check64("kill_busy", {63'h0, busy}, 64'h0);
    watch_no_done(40, "kill_no_done");
    check64("kill_res_held", MulResult, 64'h00000000_80000000);

    // reset held 2 cycles mid-CALC
    @(negedge clk);
    op = 3'b001; SrcA = 32'd9; SrcB = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check64("midrst_busy", {63'h0, busy}, 64'h0);
    check64("midrst_done", {63'h0, done}, 64'h0);
    check64("midrst_res", MulResult, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    watch_no_done(40, "midrst_no_done");

    // start held high through an op, second op accepted in DONE
    @(negedge clk);
    op = 3'b011; SrcA = 32'd3; SrcB = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    wait_done(lat);
    check_int("held_lat1", lat, 34);
    check64("held_res1", MulResult, 64'h00000000_0000000F);
    op = 3'b111; SrcA = 32'd100; SrcB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check_int("held_lat2", lat, 34);
    check64("held_res2", MulResult, 64'h00000002_0000000E);

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
